// File: rtl/counter_checker_if.sv
// Observed-counter signal bundle: the counter side drives it, the checker only samples it.
interface counter_checker_if #(
    parameter int WIDTH = 4
) ();
    logic             enb;
    logic [1:0]       modo;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic             rco;

    modport master (output enb, modo, D, Q, rco);
    modport slave  (input  enb, modo, D, Q, rco);
endinterface

// File: rtl/counter_checker.sv
// Passive reference-model checker for one counter slice: syncs on the first enabled load,
// then compares every transition and keeps error/check statistics.
module counter_checker #(
    parameter int WIDTH = 4,
    parameter int STEP  = 3,
    parameter int ERRW  = 8
) (
    input  logic                clk,
    input  logic                reset,
    counter_checker_if.slave    mon,
    input  logic                clr_stats,
    output logic                synced,
    output logic                err_q,
    output logic                err_rco,
    output logic                fail,
    output logic [ERRW-1:0]     err_count,
    output logic [15:0]         check_count
);

    typedef enum logic {
        ST_UNSYNC,
        ST_TRACK
    } state_t;

    localparam logic [WIDTH-1:0] ONE_Q  = WIDTH'(1);
    localparam logic [WIDTH-1:0] STEP_Q = WIDTH'(STEP);
    localparam logic [ERRW-1:0]  ONE_E  = ERRW'(1);

    state_t           r_state,   w_state_nxt;
    logic [WIDTH-1:0] r_exp_q,   w_exp_q_nxt;
    logic             r_exp_rco, w_exp_rco_nxt;
    logic             r_err_q,   w_err_q_nxt;
    logic             r_err_rco, w_err_rco_nxt;
    logic             r_fail,    w_fail_nxt;
    logic [ERRW-1:0]  r_ec,      w_ec_nxt;
    logic [15:0]      r_cc,      w_cc_nxt;

    logic             w_enb;
    logic [1:0]       w_modo;
    logic [WIDTH-1:0] w_d;
    logic [WIDTH-1:0] w_q;
    logic             w_rco;
    logic             w_load;
    logic             w_mis_q;
    logic             w_mis_rco;
    logic [WIDTH-1:0] w_mdl_q;
    logic             w_mdl_rco;

    assign w_enb     = mon.enb;
    assign w_modo    = mon.modo;
    assign w_d       = mon.D;
    assign w_q       = mon.Q;
    assign w_rco     = mon.rco;

    assign w_load    = w_enb && (w_modo == 2'b11);
    assign w_mis_q   = (w_q != r_exp_q);
    assign w_mis_rco = (w_rco != r_exp_rco);

    // One-step model driven by the observed Q, so a single bad transition is reported once.
    always_comb begin
        w_mdl_q   = w_q;
        w_mdl_rco = w_rco;
        if (w_enb) begin
            unique case (w_modo)
                2'b00: begin
                    w_mdl_q   = w_q + ONE_Q;
                    w_mdl_rco = (w_q == '1);
                end
                2'b01: begin
                    w_mdl_q   = w_q - ONE_Q;
                    w_mdl_rco = (w_q == '0);
                end
                2'b10: begin
                    w_mdl_q   = w_q - STEP_Q;
                    w_mdl_rco = (int'(w_q) < STEP);
                end
                default: begin
                    w_mdl_q   = w_d;
                    w_mdl_rco = (w_d == '0);
                end
            endcase
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_exp_q_nxt   = r_exp_q;
        w_exp_rco_nxt = r_exp_rco;
        w_err_q_nxt   = 1'b0;
        w_err_rco_nxt = 1'b0;
        w_fail_nxt    = r_fail;
        w_ec_nxt      = r_ec;
        w_cc_nxt      = r_cc;
        unique case (r_state)
            ST_UNSYNC: begin
                if (w_load) begin
                    w_state_nxt   = ST_TRACK;
                    w_exp_q_nxt   = w_d;
                    w_exp_rco_nxt = (w_d == '0);
                end
            end
            ST_TRACK: begin
                w_err_q_nxt   = w_mis_q;
                w_err_rco_nxt = w_mis_rco;
                w_cc_nxt      = r_cc + 16'd1;
                if (w_mis_q || w_mis_rco) begin
                    w_fail_nxt = 1'b1;
                    if (r_ec != '1) begin
                        w_ec_nxt = r_ec + ONE_E;
                    end
                end
                w_exp_q_nxt   = w_mdl_q;
                w_exp_rco_nxt = w_mdl_rco;
            end
            default: w_state_nxt = ST_UNSYNC;
        endcase
        // Clear overrides any error seen on the same edge; the flag pulses still go out.
        if (clr_stats) begin
            w_fail_nxt = 1'b0;
            w_ec_nxt   = '0;
            w_cc_nxt   = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_UNSYNC;
            r_exp_q   <= '0;
            r_exp_rco <= 1'b0;
            r_err_q   <= 1'b0;
            r_err_rco <= 1'b0;
            r_fail    <= 1'b0;
            r_ec      <= '0;
            r_cc      <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_exp_q   <= w_exp_q_nxt;
            r_exp_rco <= w_exp_rco_nxt;
            r_err_q   <= w_err_q_nxt;
            r_err_rco <= w_err_rco_nxt;
            r_fail    <= w_fail_nxt;
            r_ec      <= w_ec_nxt;
            r_cc      <= w_cc_nxt;
        end
    end

    assign synced      = (r_state == ST_TRACK);
    assign err_q       = r_err_q;
    assign err_rco     = r_err_rco;
    assign fail        = r_fail;
    assign err_count   = r_ec;
    assign check_count = r_cc;

endmodule

// File: tb/tb_counter_checker.sv
// Directed-vector bench for counter_checker: a driver queues hand-computed expectations,
// a monitor pops one per clock edge and compares against the checker outputs.
module tb_counter_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        clr_stats;
    logic        synced;
    logic        err_q;
    logic        err_rco;
    logic        fail;
    logic [7:0]  err_count;
    logic [15:0] check_count;

    int n_checks = 0;
    int n_errs   = 0;

    typedef struct {
        string nm;
        logic  xq;
        logic  xr;
        logic  xf;
        logic  xs;
        int    xec;
        int    xcc;
    } rec_t;

    rec_t sb[$];

    counter_checker_if #(.WIDTH(4)) bus ();

    counter_checker #(.WIDTH(4), .STEP(3), .ERRW(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .mon         (bus),
        .clr_stats   (clr_stats),
        .synced      (synced),
        .err_q       (err_q),
        .err_rco     (err_rco),
        .fail        (fail),
        .err_count   (err_count),
        .check_count (check_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input string fld, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errs++;
            $display("FAIL %s.%s: got %0d, expected %0d", nm, fld, act, exp);
        end
    endtask

    task automatic chk_all(input rec_t r);
        chk(r.nm, "err_q",       int'(err_q),       int'(r.xq));
        chk(r.nm, "err_rco",     int'(err_rco),     int'(r.xr));
        chk(r.nm, "fail",        int'(fail),        int'(r.xf));
        chk(r.nm, "synced",      int'(synced),      int'(r.xs));
        chk(r.nm, "err_count",   int'(err_count),   r.xec);
        chk(r.nm, "check_count", int'(check_count), r.xcc);
    endtask

    // Monitor: every edge that has a queued expectation is checked 1 time unit later.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                chk_all(sb.pop_front());
            end
        end
    end

    task automatic step(input logic e, input logic [1:0] m, input logic [3:0] d,
                        input logic [3:0] q, input logic r, input logic clr, input string nm,
                        input logic xq, input logic xr, input int xec, input int xcc,
                        input logic xf, input logic xs);
        rec_t rec;
        @(negedge clk);
        bus.enb   = e;
        bus.modo  = m;
        bus.D     = d;
        bus.Q     = q;
        bus.rco   = r;
        clr_stats = clr;
        rec.nm = nm; rec.xq = xq; rec.xr = xr; rec.xf = xf; rec.xs = xs;
        rec.xec = xec; rec.xcc = xcc;
        sb.push_back(rec);
    endtask

    task automatic chk_reset_state(input string nm);
        rec_t rec;
        rec.nm = nm; rec.xq = 1'b0; rec.xr = 1'b0; rec.xf = 1'b0; rec.xs = 1'b0;
        rec.xec = 0; rec.xcc = 0;
        chk_all(rec);
    endtask

    initial begin
        reset     = 1'b0;
        clr_stats = 1'b0;
        bus.enb   = 1'($urandom);
        bus.modo  = 2'($urandom);
        bus.D     = 4'($urandom);
        bus.Q     = 4'($urandom);
        bus.rco   = 1'($urandom);

        // Asynchronous reset, asserted away from any clock edge.
        #7;
        reset = 1'b1;
        #1;
        chk_reset_state("reset_async");
        repeat (3) begin
            @(negedge clk);
            bus.enb  = 1'($urandom);
            bus.modo = 2'($urandom);
            bus.D    = 4'($urandom);
            bus.Q    = 4'($urandom);
        end
        #1;
        chk_reset_state("reset_held");
        @(negedge clk);
        reset = 1'b0;

        // Non-load modes never synchronise.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 2'(i % 3), 4'hA, 4'(i), 1'b0, 1'b0, "unsync",
                 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        end

        // Sync on load of E, then count up through the F->0 wrap.
        step(1'b1, 2'b11, 4'hE, 4'h0, 1'b0, 1'b0, "sync_load", 1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
        step(1'b1, 2'b00, 4'h0, 4'hE, 1'b0, 1'b0, "up_E",      1'b0, 1'b0, 0, 1, 1'b0, 1'b1);
        step(1'b1, 2'b00, 4'h0, 4'hF, 1'b0, 1'b0, "up_F",      1'b0, 1'b0, 0, 2, 1'b0, 1'b1);
        step(1'b1, 2'b00, 4'h0, 4'h0, 1'b1, 1'b0, "up_wrap0",  1'b0, 1'b0, 0, 3, 1'b0, 1'b1);
        step(1'b1, 2'b00, 4'h0, 4'h1, 1'b0, 1'b0, "up_1",      1'b0, 1'b0, 0, 4, 1'b0, 1'b1);

        // Down-by-3 from 2 expects F/rco=1; the counter shows E instead.
        step(1'b1, 2'b10, 4'h0, 4'h2, 1'b0, 1'b0, "dn3_at2",   1'b0, 1'b0, 0, 5, 1'b0, 1'b1);
        step(1'b1, 2'b10, 4'h0, 4'hE, 1'b1, 1'b0, "dn3_fault", 1'b1, 1'b0, 1, 6, 1'b1, 1'b1);
        step(1'b1, 2'b01, 4'h0, 4'hB, 1'b0, 1'b0, "dn3_ok",    1'b0, 1'b0, 1, 7, 1'b1, 1'b1);

        // Reload to 5, then hold: enb=0 overrides even a load mode.
        step(1'b1, 2'b11, 4'h5, 4'hA, 1'b0, 1'b0, "dn1_ok",    1'b0, 1'b0, 1, 8, 1'b1, 1'b1);
        step(1'b0, 2'b11, 4'hF, 4'h5, 1'b0, 1'b0, "load5",     1'b0, 1'b0, 1, 9, 1'b1, 1'b1);
        step(1'b0, 2'b00, 4'h0, 4'h6, 1'b0, 1'b0, "hold_bad",  1'b1, 1'b0, 2, 10, 1'b1, 1'b1);
        step(1'b0, 2'b00, 4'h0, 4'h6, 1'b0, 1'b0, "hold_ok",   1'b0, 1'b0, 2, 11, 1'b1, 1'b1);
        step(1'b0, 2'b00, 4'h0, 4'h6, 1'b1, 1'b0, "rco_bad",   1'b0, 1'b1, 3, 12, 1'b1, 1'b1);
        step(1'b0, 2'b00, 4'h0, 4'h6, 1'b1, 1'b0, "rco_hold",  1'b0, 1'b0, 3, 13, 1'b1, 1'b1);

        // 300 consecutive hold violations saturate err_count at FF.
        for (int i = 0; i < 300; i++) begin
            step(1'b0, 2'b00, 4'h0, (i % 2 == 0) ? 4'h7 : 4'h6, 1'b1, 1'b0, "sat",
                 1'b1, 1'b0, (4 + i > 255) ? 255 : 4 + i, 14 + i, 1'b1, 1'b1);
        end

        // Clear keeps sync; a same-edge error still pulses but is not counted.
        step(1'b0, 2'b00, 4'h0, 4'h6, 1'b1, 1'b1, "clr",        1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
        step(1'b0, 2'b00, 4'h0, 4'h7, 1'b1, 1'b1, "clr_err",    1'b1, 1'b0, 0, 0, 1'b0, 1'b1);
        step(1'b0, 2'b00, 4'h0, 4'h7, 1'b1, 1'b0, "after_clr",  1'b0, 1'b0, 0, 1, 1'b0, 1'b1);

        // Reset mid-track, then resync on D=0 which must predict rco=1.
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk_reset_state("reset_mid");
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 2'b00, 4'h0, 4'h3, 1'b0, 1'b0, "post_rst",   1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        step(1'b1, 2'b11, 4'h0, 4'h3, 1'b0, 1'b0, "resync0",    1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
        step(1'b1, 2'b00, 4'h0, 4'h0, 1'b1, 1'b0, "rco_after0", 1'b0, 1'b0, 0, 1, 1'b0, 1'b1);
        step(1'b1, 2'b11, 4'h0, 4'h1, 1'b0, 1'b0, "reload0",    1'b0, 1'b0, 0, 2, 1'b0, 1'b1);
        step(1'b1, 2'b00, 4'h0, 4'h0, 1'b0, 1'b0, "rco_miss",   1'b0, 1'b1, 1, 3, 1'b1, 1'b1);

        repeat (2) @(negedge clk);
        chk("drain", "queue_left", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
